// File: rtl/mdu_issue_ctrl.sv
// mdu_issue_ctrl: issue/completion sequencer for the shared multiply/divide unit.
// Takes one RV32M op from EXE, pulses the MDU start, waits out the fixed multiply
// latency or the divider's done pulse, then holds the result on the writeback port
// until it is granted. Stalls the front of the pipe while the op is outstanding and
// publishes the pending rd for the hazard unit.
// Optional build macro: MDU_TIMEOUT_EN adds a divide watchdog that aborts the MDU,
// raises the sticky mdu_err and forces the op through writeback.
module mdu_issue_ctrl #(
    parameter int unsigned MUL_LAT     = 3,
    parameter int unsigned DIV_TIMEOUT = 40,
    parameter int unsigned CNT_W       = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       issue_valid,
    input  logic [2:0] issue_op,
    input  logic [4:0] issue_rd,
    input  logic       flush,
    input  logic       mdu_done,
    input  logic       wb_ready,
    output logic       mdu_start,
    output logic [2:0] mdu_op,
    output logic       mdu_abort,
    output logic       stall_req,
    output logic       busy_valid,
    output logic [4:0] busy_rd,
    output logic       wb_valid,
    output logic [4:0] wb_rd,
    output logic       issue_ack,
    output logic       mdu_err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_WB   = 2'd3;

    // The counter must hold both the multiply preload and the watchdog limit.
    if ((MUL_LAT < 1) || ((64'd1 << CNT_W) <= 64'(MUL_LAT)) ||
        ((64'd1 << CNT_W) <= 64'(DIV_TIMEOUT))) begin : g_param_check
        $error("mdu_issue_ctrl: MUL_LAT must be >= 1 and 2^CNT_W > max(MUL_LAT, DIV_TIMEOUT)");
    end

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic [4:0]       rd_q, rd_d;

    logic accept;
    logic wb_fire;
    logic timeout_hit;

    assign accept  = (state_q == S_IDLE) & issue_valid & ~flush;
    assign wb_fire = (state_q == S_WB) & wb_ready & ~flush;

`ifdef MDU_TIMEOUT_EN
    logic err_q;

    // Watchdog fires in the last allowed DIV cycle; a flush or done in that cycle wins.
    assign timeout_hit = (state_q == S_DIV) & ~flush & ~mdu_done &
                         (cnt_q == CNT_W'(DIV_TIMEOUT - 1));

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (timeout_hit) begin
            err_q <= 1'b1;
        end
    end

    assign mdu_err = err_q | timeout_hit;
`else
    assign timeout_hit = 1'b0;
    assign mdu_err     = 1'b0;
`endif

    // Next-state, counter and operand latch logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        rd_d    = rd_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d = issue_op;
                    rd_d = issue_rd;
                    if (issue_op[2]) begin
                        state_d = S_DIV;
                        cnt_d   = '0;
                    end else begin
                        state_d = S_MUL;
                        cnt_d   = CNT_W'(MUL_LAT - 1);
                    end
                end
            end
            S_MUL: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else if (cnt_q == '0) begin
                    state_d = S_WB;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DIV: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else if (mdu_done || timeout_hit) begin
                    state_d = S_WB;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                if (flush || wb_ready) begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    // State and operand registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            rd_q    <= rd_d;
        end
    end

    assign mdu_start  = accept;
    assign mdu_op     = op_q;
    assign mdu_abort  = ((state_q != S_IDLE) & flush) | timeout_hit;
    assign stall_req  = issue_valid & ~((state_q == S_WB) & wb_ready) & ~flush;
    assign busy_valid = (state_q != S_IDLE) & (rd_q != '0);
    assign busy_rd    = rd_q;
    // A flushed result is never offered to writeback.
    assign wb_valid   = (state_q == S_WB) & ~flush;
    assign wb_rd      = rd_q;
    assign issue_ack  = wb_fire;

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// Directed bench for mdu_issue_ctrl: inputs change 1ns after the rising edge,
// outputs are checked at the falling edge of the same cycle.
module tb_mdu_issue_ctrl;

    logic       clk;
    logic       rst_n;
    logic       issue_valid;
    logic [2:0] issue_op;
    logic [4:0] issue_rd;
    logic       flush;
    logic       mdu_done;
    logic       wb_ready;
    logic       mdu_start;
    logic [2:0] mdu_op;
    logic       mdu_abort;
    logic       stall_req;
    logic       busy_valid;
    logic [4:0] busy_rd;
    logic       wb_valid;
    logic [4:0] wb_rd;
    logic       issue_ack;
    logic       mdu_err;

    int n_cmp = 0;
    int n_err = 0;

    mdu_issue_ctrl #(
        .MUL_LAT    (3),
        .DIV_TIMEOUT(40),
        .CNT_W      (6)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .issue_valid(issue_valid),
        .issue_op   (issue_op),
        .issue_rd   (issue_rd),
        .flush      (flush),
        .mdu_done   (mdu_done),
        .wb_ready   (wb_ready),
        .mdu_start  (mdu_start),
        .mdu_op     (mdu_op),
        .mdu_abort  (mdu_abort),
        .stall_req  (stall_req),
        .busy_valid (busy_valid),
        .busy_rd    (busy_rd),
        .wb_valid   (wb_valid),
        .wb_rd      (wb_rd),
        .issue_ack  (issue_ack),
        .mdu_err    (mdu_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n       = 1'b0;
        issue_valid = 1'b0;
        issue_op    = 3'b000;
        issue_rd    = 5'd0;
        flush       = 1'b0;
        mdu_done    = 1'b0;
        wb_ready    = 1'b0;

        // Reset state
        adv();
        @(negedge clk);
        chk("rst_start", mdu_start, 0);
        chk("rst_abort", mdu_abort, 0);
        chk("rst_stall", stall_req, 0);
        chk("rst_busy",  busy_valid, 0);
        chk("rst_wbv",   wb_valid, 0);
        chk("rst_ack",   issue_ack, 0);
        chk("rst_err",   mdu_err, 0);
        chk("rst_rd_op", {busy_rd, wb_rd, mdu_op}, 0);
        adv();
        rst_n = 1'b1;
        adv();

        // MUL op=000 rd=5, wb_ready=1: start at t0, result/ack at t0+4
        issue_valid = 1'b1; issue_op = 3'b000; issue_rd = 5'd5; wb_ready = 1'b1;
        @(negedge clk);
        chk("mul_t0_start", mdu_start, 1);
        chk("mul_t0_stall", stall_req, 1);
        chk("mul_t0_busy",  busy_valid, 0);
        for (int i = 1; i <= 3; i++) begin
            adv();
            @(negedge clk);
            chk("mul_run_start", mdu_start, 0);
            chk("mul_run_stall", stall_req, 1);
            chk("mul_run_wbv",   wb_valid, 0);
            chk("mul_run_busy",  {busy_valid, busy_rd}, {1'b1, 5'd5});
        end
        chk("mul_op", mdu_op, 3'b000);
        adv();
        @(negedge clk);
        chk("mul_t4_wbv",   wb_valid, 1);
        chk("mul_t4_ack",   issue_ack, 1);
        chk("mul_t4_stall", stall_req, 0);
        chk("mul_t4_wbrd",  wb_rd, 5);
        adv();
        issue_valid = 1'b0;
        @(negedge clk);
        chk("mul_t5_idle", {busy_valid, wb_valid, issue_ack}, 0);

        // DIV op=100 rd=7, done at t0+10, writeback at t0+11
        adv();
        issue_valid = 1'b1; issue_op = 3'b100; issue_rd = 5'd7; wb_ready = 1'b1;
        @(negedge clk);
        chk("div_t0_start", mdu_start, 1);
        for (int i = 1; i <= 9; i++) begin
            adv();
            @(negedge clk);
            chk("div_run_busy", {busy_valid, busy_rd}, {1'b1, 5'd7});
            chk("div_run_wbv",  wb_valid, 0);
            chk("div_run_stall", stall_req, 1);
        end
        chk("div_op", mdu_op, 3'b100);
        adv();
        mdu_done = 1'b1;
        @(negedge clk);
        chk("div_t10_wbv",  wb_valid, 0);
        chk("div_t10_busy", busy_rd, 7);
        adv();
        mdu_done = 1'b0;
        @(negedge clk);
        chk("div_t11_wbv",  wb_valid, 1);
        chk("div_t11_ack",  issue_ack, 1);
        chk("div_t11_busy", {busy_valid, busy_rd}, {1'b1, 5'd7});
        chk("div_err",      mdu_err, 0);
        adv();
        issue_valid = 1'b0;
        @(negedge clk);
        chk("div_t12_idle", busy_valid, 0);

        // DIV op=101 rd=9 flushed at t0+5; a later mdu_done is ignored
        adv();
        issue_valid = 1'b1; issue_op = 3'b101; issue_rd = 5'd9;
        for (int i = 1; i <= 5; i++) adv();
        flush = 1'b1;
        @(negedge clk);
        chk("fl_t5_abort", mdu_abort, 1);
        chk("fl_t5_stall", stall_req, 0);
        chk("fl_t5_wbv",   wb_valid, 0);
        chk("fl_t5_ack",   issue_ack, 0);
        adv();
        flush = 1'b0; issue_valid = 1'b0; mdu_done = 1'b1;
        @(negedge clk);
        chk("fl_t6_abort", mdu_abort, 0);
        chk("fl_t6_busy",  busy_valid, 0);
        chk("fl_t6_wbv",   wb_valid, 0);
        adv();
        mdu_done = 1'b0;
        @(negedge clk);
        chk("fl_t7_wb", {wb_valid, issue_ack, busy_valid}, 0);

        // MUL op=001 rd=3 with wb_ready low for 3 WB cycles
        adv();
        issue_valid = 1'b1; issue_op = 3'b001; issue_rd = 5'd3; wb_ready = 1'b0;
        for (int i = 1; i <= 4; i++) adv();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_hold_wbv",   wb_valid, 1);
            chk("bp_hold_stall", stall_req, 1);
            chk("bp_hold_ack",   issue_ack, 0);
            adv();
        end
        wb_ready = 1'b1;
        @(negedge clk);
        chk("bp_4th_wbv",   wb_valid, 1);
        chk("bp_4th_ack",   issue_ack, 1);
        chk("bp_4th_stall", stall_req, 0);
        chk("bp_4th_wbrd",  wb_rd, 3);
        adv();

        // issue_valid with flush in IDLE: no accept, rd not latched
        issue_valid = 1'b1; issue_op = 3'b000; issue_rd = 5'd4; flush = 1'b1;
        @(negedge clk);
        chk("if_start", mdu_start, 0);
        chk("if_stall", stall_req, 0);
        chk("if_abort", mdu_abort, 0);
        adv();
        issue_valid = 1'b0; flush = 1'b0;
        @(negedge clk);
        chk("if_idle",   {busy_valid, wb_valid}, 0);
        chk("if_rd_old", busy_rd, 3);

        // rd=0 MUL completes normally; mdu_done during MUL is ignored
        adv();
        issue_valid = 1'b1; issue_op = 3'b011; issue_rd = 5'd0; wb_ready = 1'b1;
        adv();
        mdu_done = 1'b1;
        @(negedge clk);
        chk("rd0_busy", busy_valid, 0);
        chk("rd0_wbv_early", wb_valid, 0);
        adv();
        mdu_done = 1'b0;
        @(negedge clk);
        chk("rd0_t2_wbv", wb_valid, 0);
        adv();
        @(negedge clk);
        chk("rd0_t3_wbv", wb_valid, 0);
        adv();
        @(negedge clk);
        chk("rd0_t4_wb", {wb_valid, issue_ack, wb_rd}, {1'b1, 1'b1, 5'd0});
        adv();
        issue_valid = 1'b0;

        // Asynchronous reset in the middle of a DIV
        adv();
        issue_valid = 1'b1; issue_op = 3'b110; issue_rd = 5'd12; wb_ready = 1'b0;
        adv();
        adv();
        @(negedge clk);
        chk("ar_busy_pre", {busy_valid, busy_rd}, {1'b1, 5'd12});
        #1;
        rst_n = 1'b0; issue_valid = 1'b0;
        #1;
        chk("ar_busy",  {busy_valid, busy_rd, mdu_op}, 0);
        chk("ar_abort", mdu_abort, 0);
        chk("ar_wbv",   wb_valid, 0);
        adv();
        rst_n = 1'b1;
        adv();

`ifdef MDU_TIMEOUT_EN
        // DIV with no mdu_done: watchdog at the 40th DIV cycle, then WB
        issue_valid = 1'b1; issue_op = 3'b100; issue_rd = 5'd8; wb_ready = 1'b0;
        for (int i = 1; i <= 39; i++) begin
            adv();
            @(negedge clk);
            chk("to_wait_abort", mdu_abort, 0);
            chk("to_wait_err",   mdu_err, 0);
        end
        adv();
        @(negedge clk);
        chk("to_abort", mdu_abort, 1);
        chk("to_err",   mdu_err, 1);
        chk("to_wbv0",  wb_valid, 0);
        adv();
        wb_ready = 1'b1;
        @(negedge clk);
        chk("to_wb",     {wb_valid, issue_ack, wb_rd}, {1'b1, 1'b1, 5'd8});
        chk("to_err_wb", mdu_err, 1);
        adv();
        issue_valid = 1'b0;
        @(negedge clk);
        chk("to_err_sticky", mdu_err, 1);
`else
        // Without the watchdog a long DIV just keeps waiting
        issue_valid = 1'b1; issue_op = 3'b100; issue_rd = 5'd8; wb_ready = 1'b1;
        for (int i = 1; i <= 45; i++) adv();
        @(negedge clk);
        chk("nto_wait", {busy_valid, wb_valid, mdu_abort, mdu_err}, {1'b1, 1'b0, 1'b0, 1'b0});
        adv();
        mdu_done = 1'b1;
        adv();
        mdu_done = 1'b0;
        @(negedge clk);
        chk("nto_wb", {wb_valid, issue_ack}, 2'b11);
        adv();
        issue_valid = 1'b0;
`endif

        adv();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
